// File: rtl/cpu_ctrl_if.sv
// Control-path bundle between the instruction sequencer and its host/datapath.
// master: host side (drives instruction word, load, start; observes controls).
// slave:  cpu_ctrl side.
interface cpu_ctrl_if;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic [1:0]  vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   modport master (
      output in, load, s,
      input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5
   );

   modport slave (
      input  in, load, s,
      output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, shift, ALUop, sximm8, sximm5
   );
endinterface

// File: rtl/cpu_ctrl.sv
// Instruction register, decoder and Moore sequencer for the 16-bit
// register/ALU datapath. Optional retired-instruction counter is enabled
// by defining CPU_CTRL_PERF_EN (adds output instr_count).
module cpu_ctrl #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   cpu_ctrl_if.slave   bus
`ifdef CPU_CTRL_PERF_EN
   ,
   output logic [15:0] instr_count
`endif
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   // Instruction fields
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn, rd, rm;
   logic [1:0] sh;
   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   logic is_mov_imm, is_mov_reg, is_alu, is_cmp;
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);

   // Immediates follow IR directly, independent of state
   assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
   assign bus.w      = (state_q == S_WAIT);

   // State and instruction register update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= IR_RESET;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // IR capture (WAIT only) and next-state selection
   always_comb begin
      ir_d    = ir_q;
      state_d = state_q;
      case (state_q)
         S_WAIT: begin
            if (bus.load) ir_d = bus.in;
            if (bus.s) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)      state_d = S_WRITE_IMM;
            else if (is_mov_reg) state_d = S_GET_B;
            else if (is_alu)     state_d = S_GET_A;
            else                 state_d = S_WAIT;
         end
         S_WRITE_IMM: state_d = S_WAIT;
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_EXEC;
         S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_d = S_WAIT;
         default:     state_d = S_WAIT;
      endcase
   end

   // Moore datapath controls; all forced low while reset is held so nothing
   // commits on the reset edge
   always_comb begin
      bus.readnum  = 3'd0;
      bus.writenum = 3'd0;
      bus.write    = 1'b0;
      bus.vsel     = 2'b00;
      bus.loada    = 1'b0;
      bus.loadb    = 1'b0;
      bus.loadc    = 1'b0;
      bus.loads    = 1'b0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.shift    = 2'b00;
      bus.ALUop    = 2'b00;
      if (!reset) begin
         case (state_q)
            S_WRITE_IMM: begin
               bus.writenum = rn;
               bus.vsel     = 2'b10;
               bus.write    = 1'b1;
            end
            S_GET_A: begin
               bus.readnum = rn;
               bus.loada   = 1'b1;
            end
            S_GET_B: begin
               bus.readnum = rm;
               bus.loadb   = 1'b1;
            end
            S_EXEC: begin
               bus.shift = sh;
               bus.loadc = 1'b1;
               bus.loads = is_cmp;
               bus.asel  = is_mov_reg;
               bus.ALUop = is_mov_reg ? 2'b00 : op;
            end
            S_WRITE_REG: begin
               bus.writenum = rd;
               bus.vsel     = 2'b00;
               bus.write    = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef CPU_CTRL_PERF_EN
   logic [15:0] cnt_q, cnt_d;
   logic        instr_done;

   // An instruction retires when it leaves its final state
   always_comb begin
      instr_done = (state_q == S_WRITE_IMM) || (state_q == S_WRITE_REG) ||
                   ((state_q == S_EXEC) && is_cmp);
      cnt_d      = instr_done ? cnt_q + 16'd1 : cnt_q;
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 16'd0;
      else       cnt_q <= cnt_d;
   end

   assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: the driver pushes the expected control
// vector of every busy cycle, a negedge monitor pops and compares.
module tb_cpu_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cpu_ctrl_if bus ();

`ifdef CPU_CTRL_PERF_EN
   logic [15:0] instr_count;
`endif

   cpu_ctrl #(.IR_RESET(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef CPU_CTRL_PERF_EN
      ,
      .instr_count (instr_count)
`endif
   );

   typedef struct {
      string       name;
      logic [51:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   logic [51:0] act;
   assign act = {bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel,
                 bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                 bus.bsel, bus.shift, bus.ALUop, bus.sximm8, bus.sximm5};

   function automatic logic [51:0] vec(input int w, rn, wn, wr, vs, la, lb,
                                       lc, ls, asl, sh, alu,
                                       input logic [15:0] s8, s5);
      return {w[0], rn[2:0], wn[2:0], wr[0], vs[1:0], la[0], lb[0], lc[0],
              ls[0], asl[0], 1'b0, sh[1:0], alu[1:0], s8, s5};
   endfunction

   task automatic push(input string nm, input logic [51:0] v);
      exp_t e;
      e.name = nm;
      e.v    = v;
      q.push_back(e);
   endtask

   task automatic check_vec(input string nm, input logic [51:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Monitor: every busy cycle (w=0) must match the next expected vector
   always @(negedge clk) begin
      if (mon_en && !reset && bus.w === 1'b0) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy act=%h exp=none", act);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s act=%h exp=%h", e.name, act, e.v);
            end
         end
      end
   end

   task automatic run_instr(input string nm, input logic [15:0] word, input int lat);
      int n;
      @(posedge clk); #2;
      bus.in = word; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #2;
      bus.load = 1'b0; bus.s = 1'b0;
      n = 0;
      while (bus.w !== 1'b1 && n < 20) begin
         n++;
         @(posedge clk); #2;
      end
      checks++;
      if (n != lat) begin
         errors++;
         $display("FAIL %s_latency act=%0d exp=%0d", nm, n, lat);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_leftover act=%0d exp=0", nm, q.size());
         q.delete();
      end
      $display("instr %s word=%h busy=%0d", nm, word, n);
   endtask

`ifdef CPU_CTRL_PERF_EN
   task automatic check_cnt(input string nm, input logic [15:0] exp);
      checks++;
      if (instr_count !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, instr_count, exp);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      bus.in = 16'h0000; bus.load = 1'b0; bus.s = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_vec("reset_state", vec(1,0,0,0,0,0,0,0,0,0,0,0,16'h0000,16'h0000));
`ifdef CPU_CTRL_PERF_EN
      check_cnt("count_reset", 16'h0000);
`endif
      mon_en = 1'b1;

      // MOV R0,#7
      push("movi0_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0007,16'h0007));
      push("movi0_write",  vec(0,0,0,1,2,0,0,0,0,0,0,0,16'h0007,16'h0007));
      run_instr("movi_r0", 16'hD007, 2);

      // MOV R1,#-2
      push("movi1_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'hFFFE,16'hFFFE));
      push("movi1_write",  vec(0,0,1,1,2,0,0,0,0,0,0,0,16'hFFFE,16'hFFFE));
      run_instr("movi_r1", 16'hD1FE, 2);
      check_vec("idle_after_movi", vec(1,0,0,0,0,0,0,0,0,0,0,0,16'hFFFE,16'hFFFE));

      // ADD R2,R1,R0,LSL#1
      push("add_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0048,16'h0008));
      push("add_get_a",  vec(0,1,0,0,0,1,0,0,0,0,0,0,16'h0048,16'h0008));
      push("add_get_b",  vec(0,0,0,0,0,0,1,0,0,0,0,0,16'h0048,16'h0008));
      push("add_exec",   vec(0,0,0,0,0,0,0,1,0,0,1,0,16'h0048,16'h0008));
      push("add_wreg",   vec(0,0,2,1,0,0,0,0,0,0,0,0,16'h0048,16'h0008));
      run_instr("add", 16'hA148, 5);

      // CMP R1,R0
      push("cmp_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0000,16'h0000));
      push("cmp_get_a",  vec(0,1,0,0,0,1,0,0,0,0,0,0,16'h0000,16'h0000));
      push("cmp_get_b",  vec(0,0,0,0,0,0,1,0,0,0,0,0,16'h0000,16'h0000));
      push("cmp_exec",   vec(0,0,0,0,0,0,0,1,1,0,0,1,16'h0000,16'h0000));
      run_instr("cmp", 16'hA900, 4);

      // MOV R3,R2,LSR
      push("movr_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0072,16'hFFF2));
      push("movr_get_b",  vec(0,2,0,0,0,0,1,0,0,0,0,0,16'h0072,16'hFFF2));
      push("movr_exec",   vec(0,0,0,0,0,0,0,1,0,1,2,0,16'h0072,16'hFFF2));
      push("movr_wreg",   vec(0,0,3,1,0,0,0,0,0,0,0,0,16'h0072,16'hFFF2));
      run_instr("movr", 16'hC072, 4);
`ifdef CPU_CTRL_PERF_EN
      check_cnt("count_five", 16'h0005);
`endif

      // Undefined opcode: one DECODE cycle, nothing asserted
      push("undef_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0000,16'h0000));
      run_instr("undef", 16'hE000, 1);
`ifdef CPU_CTRL_PERF_EN
      check_cnt("count_undef", 16'h0005);
`endif

      // ADD aborted by reset in WRITE_REG; load attempted in GET_A
      push("abort_decode", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0048,16'h0008));
      push("abort_get_a",  vec(0,1,0,0,0,1,0,0,0,0,0,0,16'h0048,16'h0008));
      push("abort_get_b",  vec(0,0,0,0,0,0,1,0,0,0,0,0,16'h0048,16'h0008));
      push("abort_exec",   vec(0,0,0,0,0,0,0,1,0,0,1,0,16'h0048,16'h0008));
      @(posedge clk); #2;
      bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #2;                      // DECODE
      bus.load = 1'b0; bus.s = 1'b0;
      @(posedge clk); #2;                      // GET_A: load must be ignored
      bus.in = 16'hFFFF; bus.load = 1'b1;
      @(posedge clk); #2;                      // GET_B
      bus.load = 1'b0;
      @(posedge clk); #2;                      // EXEC
      @(posedge clk); #1;                      // WRITE_REG
      reset = 1'b1;
      #1 check_vec("reset_in_wreg", vec(0,0,0,0,0,0,0,0,0,0,0,0,16'h0048,16'h0008));
      @(posedge clk); #2;
      reset = 1'b0;
      #1 check_vec("after_abort", vec(1,0,0,0,0,0,0,0,0,0,0,0,16'h0000,16'h0000));
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL abort_leftover act=%0d exp=0", q.size());
      end
      $display("instr abort word=a148 reset_in_write_reg");
`ifdef CPU_CTRL_PERF_EN
      check_cnt("count_after_reset", 16'h0000);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Instruction register, decoder and Moore FSM that sequence the 16-bit register/ALU datapath one instruction at a time.
- Drives every datapath control (register-file read/write, A/B/C/status load enables, source selects, shift, ALUop) and the sign-extended immediates.
- Start/done handshake with the testbench or top level via s/w.

Parameters:
IR_RESET, 16'h0000, instruction register value after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
in  in  16  instruction word
load  in  1  capture in into IR (honoured only in WAIT)
s  in  1  start execution of IR contents (level, sampled in WAIT)
w  out  1  1 = idle in WAIT, ready for load/s
readnum  out  3  register-file read address
writenum  out  3  register-file write address
write  out  1  register-file write enable
vsel  out  2  writeback select: 11 mdata, 10 sximm8, 01 PC, 00 C
loada  out  1  A register load
loadb  out  1  B register load
loadc  out  1  C register load
loads  out  1  status register load
asel  out  1  1 = A operand forced to zero
bsel  out  1  1 = B operand is sximm5 (always 0 in this ISA)
shift  out  2  shifter control
ALUop  out  2  ALU operation
sximm8  out  16  sign-extended IR[7:0]
sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR fields: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0].
- Decoded instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN
  - All other opcode/op values are undefined.
- Moore outputs are a function of the state and IR only. Any control not listed for a state is 0. sximm8 and sximm5 are continuous from IR.
- States and transitions:
  - WAIT: w=1. If s=1, go to DECODE.
  - DECODE:
    - MOV imm goes to WRITE_IMM.
    - MOV reg goes to GET_B.
    - 101 ops go to GET_A.
    - Undefined goes to WAIT with no side effects.
  - WRITE_IMM: writenum=Rn, vsel=10, write=1. Go to WAIT.
  - GET_A: readnum=Rn, loada=1. Go to GET_B.
  - GET_B: readnum=Rm, loadb=1. Go to EXEC.
  - EXEC:
    - shift=sh, bsel=0, loadc=1.
    - MOV reg: asel=1, ALUop=00. All others: asel=0, ALUop=op.
    - loads=1 only for CMP.
    - CMP goes to WAIT; all others go to WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=00, write=1. Go to WAIT.
- Latency (cycles with w=0 after s sampled): MOV imm 2, MOV reg 4, CMP 4, ADD/AND/MVN 5.
- Every instruction returns to WAIT for at least one cycle. If s is still 1 there, the next instruction starts on the following edge.
- load=1 in WAIT updates IR on that edge. load outside WAIT is ignored.
- load and s together in WAIT: the new word is captured and DECODE acts on the new IR.
- Status register changes only on CMP. C register is loaded on every EXEC.
- Reset:
  - On the reset edge, state becomes WAIT and IR becomes IR_RESET.
  - While reset=1, all control outputs are forced to 0 combinationally, regardless of state, so no write, load or status update commits on a reset edge.
  - After reset: w=1, all other controls 0, sximm8 and sximm5 derived from IR_RESET (0 by default).

Optional Feature:
- Macro CPU_CTRL_PERF_EN.
- When defined:
  - Adds output instr_count[15:0], reset to 0.
  - Increments by 1 on each completed defined instruction, i.e. leaving WRITE_IMM, WRITE_REG, or EXEC for CMP.
  - Wraps FFFF to 0000.
  - Undefined opcodes and reset-aborted instructions are not counted.
- When undefined: no port, no counter logic.

Test Plan:
- Reset, then load 16'hD007 + s (MOV R0,#7) -> w=0 for 2 cycles; WRITE_IMM shows write=1, writenum=0, vsel=10, sximm8=16'h0007; then w=1.
- load 16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE, writenum=1, write=1 in WRITE_IMM only.
- load 16'hA148 (ADD R2,R1,R0,LSL#1) ->
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - EXEC: shift=01, asel=0, ALUop=00, loadc=1, loads=0
  - WRITE_REG: writenum=2, vsel=00, write=1
  - w returns after 5 cycles.
- load 16'hA900 (CMP R1,R0) -> EXEC: ALUop=01, loads=1, loadc=1; write never asserted; w=1 after 4 cycles. Then 16'hC072 (MOV R3,R2,LSR) -> GET_B readnum=2; EXEC asel=1, shift=10; WRITE_REG writenum=3.
- Undefined 16'hE000 + s -> DECODE then WAIT; no load/write/loads asserted; with CPU_CTRL_PERF_EN, instr_count unchanged.
- Assert reset during WRITE_REG of 16'hA148 -> write=0 that cycle; next cycle w=1, IR=16'h0000; load attempted mid-instruction (e.g. in GET_A) leaves IR unchanged.
